// File: rtl/pll_rst_seq.sv
// pll_rst_seq: reset sequencer for the clk_wiz_0 PLL.
// It drives the PLL reset and synchronizes the asynchronous `locked` flag.
// It releases the downstream system reset only after lock has been stable
// for STABLE_CYCLES clocks. A PLL that fails to lock within LOCK_TIMEOUT
// clocks is reset again. Lock loss while running re-asserts the system reset.
//
// Optional feature: define PLL_RST_SEQ_LOSS_CNT_EN to add the `loss_cnt`
// output. It is a saturating count of RUN -> WAIT_LOCK transitions.
`timescale 1ns/1ps

module pll_rst_seq #(
  parameter int SYNC_STAGES    = 2,       // >= 2
  parameter int STABLE_CYCLES  = 1000,    // >= 1
  parameter int LOCK_TIMEOUT   = 100000,  // >= 1
  parameter int PLL_RST_CYCLES = 16       // >= 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       lock_lost,
  output logic [7:0] retry_cnt,
  output logic [1:0] state
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Saturating 8-bit increment, shared by the retry and loss counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  localparam int CNT_MAX = max3(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [SYNC_STAGES-1:0] locked_sync;
  logic                   locked_s;
  logic                   pll_reset_nxt;
  logic                   sys_rst_n_nxt;
  logic                   lock_lost_nxt;
  logic [7:0]             retry_nxt;

  // Metastability chain for the asynchronous PLL lock flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked_sync <= '0;
    end else begin
      locked_sync <= {locked_sync[SYNC_STAGES-2:0], locked};
    end
  end

  assign locked_s = locked_sync[SYNC_STAGES-1];

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_nxt     = state_q;
    retry_nxt     = retry_cnt;
    lock_lost_nxt = 1'b0;

    case (state_q)
      PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (locked_s) begin
          state_nxt = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_nxt = PLL_RST;
          retry_nxt = sat_inc8(retry_cnt);
        end
      end
      STABLE: begin
        // A dropout restarts the whole lock search, including the timeout.
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt     = WAIT_LOCK;
          lock_lost_nxt = 1'b1;
        end
      end
      default: state_nxt = PLL_RST;
    endcase

    // The counter restarts on every state change and is idle in RUN.
    if (state_nxt != state_q) begin
      cnt_nxt = '0;
    end else if (state_q == RUN) begin
      cnt_nxt = cnt_q;
    end else begin
      cnt_nxt = cnt_q + 1'b1;
    end

    // Outputs are decoded from the next state so that they move with `state`.
    pll_reset_nxt = (state_nxt == PLL_RST);
    sys_rst_n_nxt = (state_nxt == RUN);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      lock_lost <= 1'b0;
      retry_cnt <= 8'd0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      pll_reset <= pll_reset_nxt;
      sys_rst_n <= sys_rst_n_nxt;
      lock_lost <= lock_lost_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  assign state = state_q;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  // Saturating count of lock losses seen while running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loss_cnt <= 8'd0;
    end else if (lock_lost_nxt) begin
      loss_cnt <= sat_inc8(loss_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Scoreboard bench for pll_rst_seq (SYNC=2, STABLE=8, TIMEOUT=64, PLL_RST=4).
`timescale 1ns/1ps

module tb_pll_rst_seq;

  localparam int SEL_ST = 0;
  localparam int SEL_PR = 1;
  localparam int SEL_SR = 2;
  localparam int SEL_LL = 3;
  localparam int SEL_RC = 4;
  localparam int SEL_LC = 5;

  typedef struct {
    int    tag;
    int    sel;
    int    val;
    string name;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       locked;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       lock_lost;
  logic [7:0] retry_cnt;
  logic [1:0] state;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  exp_t q[$];
  int   cyc       = 0;
  int   n_run     = 0;
  int   n_fail    = 0;
  logic stim_done = 1'b0;

  pll_rst_seq #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .LOCK_TIMEOUT  (64),
    .PLL_RST_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .locked   (locked),
    .pll_reset(pll_reset),
    .sys_rst_n(sys_rst_n),
    .lock_lost(lock_lost),
    .retry_cnt(retry_cnt),
    .state    (state)
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    ,
    .loss_cnt (loss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Edge counter: after the k-th rising edge, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int sel);
    case (sel)
      SEL_ST: return int'(state);
      SEL_PR: return int'(pll_reset);
      SEL_SR: return int'(sys_rst_n);
      SEL_LL: return int'(lock_lost);
      SEL_RC: return int'(retry_cnt);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      SEL_LC: return int'(loss_cnt);
`endif
      default: return -1;
    endcase
  endfunction

  // Monitor: on each falling edge, compare every expectation due now.
  always @(negedge clk) begin
    int i;
    int a;
    i = 0;
    while (i < q.size()) begin
      if (q[i].tag == cyc) begin
        a = actual(q[i].sel);
        n_run++;
        if (a != q[i].val) begin
          n_fail++;
          $display("FAIL %s edge=%0d got=%0d want=%0d", q[i].name, cyc, a, q[i].val);
        end
        q.delete(i);
      end else if (q[i].tag < cyc || stim_done) begin
        n_run++;
        n_fail++;
        $display("FAIL %s edge=%0d never checked (due at %0d)", q[i].name, cyc, q[i].tag);
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic chk(input int tag, input int sel, input int val, input string name);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #(20 * 40000);
    $display("FAIL watchdog edge=%0d expired", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, g, r, w, wp, t255, t256, c;

    // Normal lock after a 25-clock reset.
    rst_n = 1'b0;
    locked = 1'b0;
    tick(25);
    c = cyc;
    chk(c, SEL_ST, 0, "rst_state");
    chk(c, SEL_PR, 1, "rst_pll_reset");
    chk(c, SEL_SR, 0, "rst_sys_rst_n");
    chk(c, SEL_LL, 0, "rst_lock_lost");
    chk(c, SEL_RC, 0, "rst_retry");
    rst_n = 1'b1;
    chk(c + 3, SEL_PR, 1, "pllrst_hold");
    chk(c + 4, SEL_PR, 0, "pllrst_fall");
    chk(c + 4, SEL_ST, 1, "enter_wait");
    tick(10);
    locked = 1'b1;
    e0 = cyc + 1;
    chk(e0 + 1, SEL_ST, 1, "lock_sync_wait");
    chk(e0 + 2, SEL_ST, 2, "enter_stable");
    chk(e0 + 9, SEL_SR, 0, "sysrst_before_run");
    chk(e0 + 10, SEL_SR, 1, "sysrst_release");
    chk(e0 + 10, SEL_ST, 3, "enter_run");
    chk(e0 + 10, SEL_RC, 0, "retry_zero");
    tick(15);

    // Lock loss in RUN.
    locked = 1'b0;
    e0 = cyc + 1;
    chk(e0 + 1, SEL_SR, 1, "loss_sysrst_hold");
    chk(e0 + 1, SEL_LL, 0, "loss_pulse_early");
    chk(e0 + 2, SEL_SR, 0, "loss_sysrst_fall");
    chk(e0 + 2, SEL_LL, 1, "loss_pulse");
    chk(e0 + 2, SEL_ST, 1, "loss_to_wait");
    chk(e0 + 3, SEL_LL, 0, "loss_pulse_end");
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    chk(e0 + 1, SEL_LC, 0, "loss_cnt_before");
    chk(e0 + 2, SEL_LC, 1, "loss_cnt_one");
`endif
    tick(4);

    // One-clock dropout five clocks into STABLE.
    locked = 1'b1;
    e0 = cyc + 1;
    chk(e0 + 2, SEL_ST, 2, "glitch_stable");
    tick(8);
    locked = 1'b0;
    g = cyc + 1;
    chk(g + 1, SEL_ST, 2, "glitch_still_stable");
    chk(g + 2, SEL_ST, 1, "glitch_to_wait");
    chk(g + 2, SEL_SR, 0, "glitch_sysrst_low");
    chk(g + 2, SEL_LL, 0, "glitch_no_pulse");
    chk(g + 3, SEL_ST, 2, "glitch_relock");
    chk(g + 10, SEL_ST, 2, "glitch_full_window");
    chk(g + 10, SEL_SR, 0, "glitch_sysrst_wait");
    chk(g + 11, SEL_ST, 3, "glitch_run");
    chk(g + 11, SEL_SR, 1, "glitch_sysrst_rel");
    tick(1);
    locked = 1'b1;
    tick(14);

    // Second loss, relock, then a one-clock reset two clocks into STABLE.
    locked = 1'b0;
    e0 = cyc + 1;
    chk(e0 + 2, SEL_LL, 1, "loss2_pulse");
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    chk(e0 + 2, SEL_LC, 2, "loss_cnt_two");
`endif
    tick(4);
    locked = 1'b1;
    e0 = cyc + 1;
    chk(e0 + 2, SEL_ST, 2, "pre_rst_stable");
    tick(5);
    rst_n = 1'b0;
    r = cyc + 1;
    chk(r, SEL_ST, 0, "midrst_state");
    chk(r, SEL_PR, 1, "midrst_pll_reset");
    chk(r, SEL_SR, 0, "midrst_sys_rst_n");
    chk(r, SEL_LL, 0, "midrst_lock_lost");
    chk(r, SEL_RC, 0, "midrst_retry");
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    chk(r, SEL_LC, 0, "midrst_loss_cnt");
`endif
    chk(r + 3, SEL_PR, 1, "midrst_pll_hold");
    chk(r + 4, SEL_PR, 0, "midrst_pll_fall");
    chk(r + 4, SEL_ST, 1, "midrst_wait");
    chk(r + 5, SEL_ST, 2, "midrst_stable");
    chk(r + 13, SEL_ST, 3, "midrst_run");
    chk(r + 13, SEL_SR, 1, "midrst_sysrst_rel");
    tick(1);
    rst_n = 1'b1;
    tick(15);

    // Lock arriving on the timeout cycle.
    locked = 1'b0;
    w = cyc + 3;
    chk(w, SEL_ST, 1, "sim_wait");
    chk(w, SEL_LL, 1, "sim_loss_pulse");
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    chk(w, SEL_LC, 1, "sim_loss_cnt");
`endif
    chk(w + 63, SEL_ST, 1, "sim_wait_last");
    chk(w + 64, SEL_ST, 2, "sim_lock_wins");
    chk(w + 64, SEL_RC, 0, "sim_retry_same");
    chk(w + 64, SEL_PR, 0, "sim_no_pll_reset");
    chk(w + 65, SEL_ST, 2, "sim_stays_stable");
    tick(64);
    locked = 1'b1;
    tick(5);

    // Lock removed in STABLE, then never returns.
    locked = 1'b0;
    wp = cyc + 3;
    t255 = wp + 64 + 68 * 254;
    t256 = t255 + 68;
    chk(wp - 1, SEL_ST, 2, "nolock_stable");
    chk(wp, SEL_ST, 1, "nolock_wait");
    chk(wp, SEL_LL, 0, "nolock_no_pulse");
    chk(wp + 63, SEL_ST, 1, "nolock_wait_last");
    chk(wp + 63, SEL_PR, 0, "nolock_pll_low");
    chk(wp + 64, SEL_ST, 0, "timeout1_state");
    chk(wp + 64, SEL_PR, 1, "timeout1_pll");
    chk(wp + 64, SEL_RC, 1, "timeout1_retry");
    chk(wp + 67, SEL_PR, 1, "timeout1_pll_hold");
    chk(wp + 68, SEL_PR, 0, "timeout1_pll_fall");
    chk(wp + 68, SEL_ST, 1, "timeout1_rewait");
    chk(wp + 131, SEL_RC, 1, "timeout2_before");
    chk(wp + 132, SEL_RC, 2, "timeout2_retry");
    chk(wp + 200, SEL_RC, 3, "timeout3_retry");
    chk(t255 - 1, SEL_RC, 254, "retry_254");
    chk(t255, SEL_RC, 255, "retry_255");
    chk(t256, SEL_ST, 0, "timeout256_state");
    chk(t256, SEL_RC, 255, "retry_saturated");
    chk(t256, SEL_SR, 0, "nolock_sysrst_low");
    chk(t256 + 4, SEL_ST, 1, "timeout256_rewait");
    tick(t256 + 6 - cyc);

    stim_done = 1'b1;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
